// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare branch predictor with 2-bit saturating counters
//
// Purpose: same-cycle taken/not-taken guess for decode, indexed by PC xor global
// history; execute writes resolved outcomes back through the carried index.
// After reset a sweep sets every counter to INIT_CTR; busy is high while it runs.
//
// Optional feature: define BP_STATS_EN to build the lookup/mispredict counters;
// otherwise both stat ports read 0 and no counter flops exist.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   busy                   1 while the init sweep runs
//   pred_valid, pred_pc    decode-stage branch and its PC
//   pred_taken, pred_index combinational prediction and table index used
//   upd_valid, upd_index,  execute-stage resolution: carried index, outcome,
//   upd_taken,             and mispredict flag (stats only)
//   upd_mispredict
//   stat_lookups,          accepted lookups / resolved mispredictions
//   stat_mispredicts

module gshare_predictor #(
    parameter int          IDX_BITS  = 10,
    parameter int          HIST_BITS = 8,
    parameter logic [1:0]  INIT_CTR  = 2'b01
) (
    input  logic                clk,
    input  logic                resetn,
    output logic                busy,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                pred_taken,
    output logic [IDX_BITS-1:0] pred_index,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_index,
    input  logic                upd_taken,
    input  logic                upd_mispredict,
    output logic [31:0]         stat_lookups,
    output logic [31:0]         stat_mispredicts
);

    localparam int DEPTH = 1 << IDX_BITS;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_BITS-1:0]   init_ptr_q, init_ptr_d;
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic [1:0]            ctr_q [DEPTH];

    logic [IDX_BITS-1:0]   lookup_idx;
    logic [HIST_BITS:0]    ghr_shift;
    logic [1:0]            upd_old;
    logic [1:0]            upd_new;
    logic                  upd_en;

    // Short histories are zero-extended into the upper index bits.
    assign lookup_idx = pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    assign pred_index = lookup_idx;
    assign pred_taken = (state_q == ST_RUN) & ctr_q[lookup_idx][1];
    assign busy       = (state_q == ST_INIT);

    assign upd_en  = (state_q == ST_RUN) & upd_valid;
    assign upd_old = ctr_q[upd_index];

    always_comb begin
        upd_new = upd_old;
        if (upd_taken) begin
            if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
        end else begin
            if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
        end
    end

    // Shifting through one extra bit keeps HIST_BITS==1 legal without a special case.
    assign ghr_shift = {ghr_q, upd_taken};
    assign ghr_d     = upd_en ? ghr_shift[HIST_BITS-1:0] : ghr_q;

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            ST_INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == {IDX_BITS{1'b1}}) state_d = ST_RUN;
            end
            ST_RUN:  ;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            ghr_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ghr_q      <= ghr_d;
        end
    end

    // The table has no reset term: the sweep is what clears it, so a reset
    // simply suppresses writes and restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (state_q == ST_INIT) begin
                ctr_q[init_ptr_q] <= INIT_CTR;
            end else if (upd_valid) begin
                ctr_q[upd_index] <= upd_new;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_lookups_q;
    logic [31:0] stat_mispredicts_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_lookups_q     <= '0;
            stat_mispredicts_q <= '0;
        end else if (state_q == ST_RUN) begin
            if (pred_valid) stat_lookups_q <= stat_lookups_q + 32'd1;
            if (upd_valid && upd_mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign stat_lookups     = stat_lookups_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    assign stat_lookups     = 32'd0;
    assign stat_mispredicts = 32'd0;

    logic unused_stat_inputs;
    assign unused_stat_inputs = &{1'b0, pred_valid, upd_mispredict};
`endif

    // Only pred_pc[IDX_BITS+1:2] feeds the index.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, pred_pc};

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - randomized check of gshare_predictor against a table model

module tb_gshare_predictor;

    localparam int IB = 4;
    localparam int HB = 2;
    localparam int NENT = 16;

`ifdef BP_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          busy;
    logic          pred_valid;
    logic [31:0]   pred_pc;
    logic          pred_taken;
    logic [IB-1:0] pred_index;
    logic          upd_valid;
    logic [IB-1:0] upd_index;
    logic          upd_taken;
    logic          upd_mispredict;
    logic [31:0]   stat_lookups;
    logic [31:0]   stat_mispredicts;

    gshare_predictor #(.IDX_BITS(IB), .HIST_BITS(HB), .INIT_CTR(2'b01)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .busy             (busy),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .pred_index       (pred_index),
        .upd_valid        (upd_valid),
        .upd_index        (upd_index),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: counter values as plain integers, history as a number,
    // and the number of sweep cycles still to go.
    int tab [NENT];
    int ghr;
    int init_left;
    bit mdl_valid = 1'b0;
    int n_look;
    int n_mis;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic setin(input logic rn, input logic pv, input logic [31:0] pc,
                         input logic uv, input logic [IB-1:0] ui, input logic ut, input logic um);
        resetn         = rn;
        pred_valid     = pv;
        pred_pc        = pc;
        upd_valid      = uv;
        upd_index      = ui;
        upd_taken      = ut;
        upd_mispredict = um;
    endtask

    task automatic model_edge(input logic rn, input logic pv, input logic uv,
                              input int ui, input logic ut, input logic um);
        if (!rn) begin
            mdl_valid = 1'b1;
            init_left = NENT;
            ghr       = 0;
            n_look    = 0;
            n_mis     = 0;
        end else if (init_left > 0) begin
            init_left--;
            if (init_left == 0)
                for (int i = 0; i < NENT; i++) tab[i] = 1;
        end else begin
            if (pv) n_look++;
            if (uv) begin
                if (ut) tab[ui] = (tab[ui] == 3) ? 3 : tab[ui] + 1;
                else    tab[ui] = (tab[ui] == 0) ? 0 : tab[ui] - 1;
                ghr = ((ghr * 2) + (ut ? 1 : 0)) % (1 << HB);
                if (um) n_mis++;
            end
        end
    endtask

    // One clock: apply inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic cyc(input logic rn, input logic pv, input logic [31:0] pc,
                       input logic uv, input logic [IB-1:0] ui, input logic ut, input logic um);
        int idx;
        bit run;
        setin(rn, pv, pc, uv, ui, ut, um);
        #1;
        if (mdl_valid) begin
            idx = ((pc >> 2) % NENT) ^ ghr;
            run = (init_left == 0);
            check("busy", {31'd0, busy}, {31'd0, !run});
            check("pred_index", {28'd0, pred_index}, idx);
            check("pred_taken", {31'd0, pred_taken}, {31'd0, run && (tab[idx] >= 2)});
            check("stat_lookups", stat_lookups, STATS_ON ? n_look : 0);
            check("stat_mispredicts", stat_mispredicts, STATS_ON ? n_mis : 0);
        end
        @(posedge clk);
        model_edge(rn, pv, uv, int'(ui), ut, um);
        @(negedge clk);
    endtask

    task automatic do_reset_and_sweep(input bit noisy);
        cyc(1'b0, 1'b1, 32'h0, 1'b1, 4'h3, 1'b1, 1'b1);
        for (int i = 0; i < NENT; i++) begin
            if (noisy) cyc(1'b1, 1'b1, $urandom, 1'b1, 4'($urandom), 1'b1, 1'b1);
            else       cyc(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < NENT; i++) tab[i] = 0;
        ghr = 0; init_left = 0; n_look = 0; n_mis = 0;
        setin(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset held for several cycles, then the sweep.
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_pred", {31'd0, pred_taken}, 32'd0);
        do_reset_and_sweep(1'b0);
        #1;
        check("t1_busy_done", {31'd0, busy}, 32'd0);
        for (int p = 0; p < 16; p++) begin
            setin(1'b1, 1'b0, 32'(p * 4), 1'b0, 4'h0, 1'b0, 1'b0);
            #1;
            check("t1_pred0", {31'd0, pred_taken}, 32'd0);
            cyc(1'b1, 1'b0, 32'(p * 4), 1'b0, 4'h0, 1'b0, 1'b0);
        end

        // Train entry 0 taken three times; ghr becomes 2'b11.
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 32'h100, 1'b1, 4'h0, 1'b1, 1'b0);
        setin(1'b1, 1'b0, 32'h10C, 1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        check("t2_index", {28'd0, pred_index}, 32'd0);
        check("t2_pred", {31'd0, pred_taken}, 32'd1);
        cyc(1'b1, 1'b0, 32'h10C, 1'b0, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h10C, 1'b1, 4'h0, 1'b1, 1'b0);

        // Saturating decrement of entry 0: reads 1,0,0,0.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0);
            setin(1'b1, 1'b0, 32'(ghr * 4), 1'b0, 4'h0, 1'b0, 1'b0);
            #1;
            check("t3_dec", {31'd0, pred_taken}, (k == 0) ? 32'd1 : 32'd0);
            cyc(1'b1, 1'b0, 32'(ghr * 4), 1'b0, 4'h0, 1'b0, 1'b0);
        end

        // Train some more, then reset for one cycle with updates during the sweep.
        for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, $urandom, 1'b1, 4'($urandom), 1'b1, 1'b0);
        do_reset_and_sweep(1'b1);
        setin(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        check("t5_ghr0", {28'd0, pred_index}, 32'd0);
        for (int p = 0; p < 16; p++) begin
            setin(1'b1, 1'b0, 32'(p * 4), 1'b0, 4'h0, 1'b0, 1'b0);
            #1;
            check("t5_init", {31'd0, pred_taken}, 32'd0);
            cyc(1'b1, 1'b0, 32'(p * 4), 1'b0, 4'h0, 1'b0, 1'b0);
        end

        // Same-cycle lookup and update on index 5.
        setin(1'b1, 1'b0, 32'h14, 1'b1, 4'h5, 1'b1, 1'b0);
        #1;
        check("t4_same", {31'd0, pred_taken}, 32'd0);
        cyc(1'b1, 1'b0, 32'h14, 1'b1, 4'h5, 1'b1, 1'b0);
        setin(1'b1, 1'b0, 32'h10, 1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        check("t4_index", {28'd0, pred_index}, 32'd5);
        check("t4_next", {31'd0, pred_taken}, 32'd1);
        cyc(1'b1, 1'b0, 32'h10, 1'b0, 4'h0, 1'b0, 1'b0);

        // Stats: 5 of each during INIT are ignored, 10 lookups + 3 mispredicts count.
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < NENT; i++)
            cyc(1'b1, i < 5, 32'h40, i < 5, 4'h1, 1'b0, i < 5);
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b1, 32'(i * 4), i < 3, 4'(i), 1'b1, i < 3);
        #1;
        check("t6_lookups", stat_lookups, STATS_ON ? 32'd10 : 32'd0);
        check("t6_mispred", stat_mispredicts, STATS_ON ? 32'd3 : 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0), 1'($urandom), $urandom, 1'($urandom),
                4'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
